// File: rtl/gcd_arbiter_if.sv
// Requester-side and gcd-side signal bundle for gcd_arbiter.
// master is the arbiter's view; slave is the view of the requesters and the gcd datapath.
interface gcd_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 8
);
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic [NREQ-1:0]   ack;
  logic [W-1:0]      rsp_q;
  logic [NREQ-1:0]   rsp_done;
  logic [NREQ-1:0]   rsp_err;
  logic [W-1:0]      g_a;
  logic [W-1:0]      g_b;
  logic              g_ld;
  logic [W-1:0]      g_q;
  logic              g_rdy;

  modport master (
    input  req, req_a, req_b, g_q, g_rdy,
    output ack, rsp_q, rsp_done, rsp_err, g_a, g_b, g_ld
  );

  modport slave (
    output req, req_a, req_b, g_q, g_rdy,
    input  ack, rsp_q, rsp_done, rsp_err, g_a, g_b, g_ld
  );
endinterface

// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one gcd datapath among NREQ requesters.
// Define GCD_ARB_TIMEOUT_EN to enable the BUSY watchdog (TIMEOUT cycles, reported on rsp_err).
module gcd_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 255
) (
  input logic           clk,
  input logic           reset,
  gcd_arbiter_if.master bus
);
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t          state_r, state_s;
  logic [PW-1:0]   owner_r, owner_s, ptr_r, ptr_s, win_s, cand_s;
  logic            found_s, hit_s, fire_s;
  logic [NREQ-1:0] ack_r, ack_s, done_r, done_s;
  logic [W-1:0]    rsp_q_r, rsp_q_s, g_a_r, g_a_s, g_b_r, g_b_s;
  logic            g_ld_r, g_ld_s;
  logic [W-1:0]    opa_s [NREQ];
  logic [W-1:0]    opb_s [NREQ];

`ifdef GCD_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic [NREQ-1:0] err_r, err_s;
`endif

  function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
    logic [NREQ-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    return (int'(idx) >= NREQ - 1) ? '0 : idx + PW'(1);
  endfunction

  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign opa_s[g] = bus.req_a[g*W +: W];
    assign opb_s[g] = bus.req_b[g*W +: W];
  end

  // Round-robin search: first requester at or after ptr_r, wrapping.
  always_comb begin
    win_s   = '0;
    found_s = 1'b0;
    cand_s  = '0;
    hit_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      cand_s  = PW'((int'(ptr_r) + i) % NREQ);
      hit_s   = bus.req[cand_s] & ~found_s;
      win_s   = hit_s ? cand_s : win_s;
      found_s = found_s | hit_s;
    end
  end

  // Next-state and next-output logic for the IDLE/BUSY sequencer.
  always_comb begin
    state_s = state_r;
    owner_s = owner_r;
    ptr_s   = ptr_r;
    ack_s   = '0;
    done_s  = '0;
    g_ld_s  = 1'b0;
    g_a_s   = g_a_r;
    g_b_s   = g_b_r;
    rsp_q_s = rsp_q_r;
    fire_s  = bus.g_rdy & ~g_ld_r;
`ifdef GCD_ARB_TIMEOUT_EN
    cnt_s   = cnt_r;
    err_s   = '0;
`endif
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_s = BUSY;
          owner_s = win_s;
          ack_s   = onehot(win_s);
          g_ld_s  = 1'b1;
          g_a_s   = opa_s[win_s];
          g_b_s   = opb_s[win_s];
`ifdef GCD_ARB_TIMEOUT_EN
          cnt_s   = '0;
`endif
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        if (fire_s) begin
          rsp_q_s = bus.g_q;
          done_s  = onehot(owner_r);
          ptr_s   = next_idx(owner_r);
          state_s = IDLE;
        end
`ifdef GCD_ARB_TIMEOUT_EN
        // A completion on the limit cycle takes priority over the error.
        else if (cnt_r == CW'(TIMEOUT - 1)) begin
          err_s   = onehot(owner_r);
          ptr_s   = next_idx(owner_r);
          state_s = IDLE;
        end else begin
          cnt_s   = cnt_r + CW'(1);
        end
`else
        else begin
          state_s = BUSY;
        end
`endif
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      owner_r <= '0;
      ptr_r   <= '0;
      ack_r   <= '0;
      done_r  <= '0;
      rsp_q_r <= '0;
      g_a_r   <= '0;
      g_b_r   <= '0;
      g_ld_r  <= 1'b0;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_r   <= '0;
      err_r   <= '0;
`endif
    end else begin
      state_r <= state_s;
      owner_r <= owner_s;
      ptr_r   <= ptr_s;
      ack_r   <= ack_s;
      done_r  <= done_s;
      rsp_q_r <= rsp_q_s;
      g_a_r   <= g_a_s;
      g_b_r   <= g_b_s;
      g_ld_r  <= g_ld_s;
`ifdef GCD_ARB_TIMEOUT_EN
      cnt_r   <= cnt_s;
      err_r   <= err_s;
`endif
    end
  end

  assign bus.ack      = ack_r;
  assign bus.rsp_done = done_r;
  assign bus.rsp_q    = rsp_q_r;
  assign bus.g_a      = g_a_r;
  assign bus.g_b      = g_b_r;
  assign bus.g_ld     = g_ld_r;
`ifdef GCD_ARB_TIMEOUT_EN
  assign bus.rsp_err  = err_r;
`else
  assign bus.rsp_err  = '0;
`endif
endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural gcd stub (fixed latency, can be muted).
// Define GCD_ARB_TIMEOUT_EN to exercise the watchdog instead of the indefinite wait.
module tb_gcd_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  int   cyc = 0;

  int         pending [4];
  logic [7:0] opa [4];
  logic [7:0] opb [4];
  logic       force_rdy = 1'b0;
  logic       stub_en = 1'b1;
  logic       stub_rdy;
  logic [7:0] sq;
  int         cd;

  logic [3:0] gr_ack [$];
  logic [7:0] gr_a [$];
  logic [7:0] gr_b [$];
  logic       gr_ld [$];
  int         gr_cyc [$];
  logic [3:0] dn_v [$];
  logic [7:0] dn_q [$];
  int         dn_cyc [$];
  logic [3:0] er_v [$];
  int         er_cyc [$];

  gcd_arbiter_if #(.NREQ(4), .W(8)) bus ();

  gcd_arbiter #(.NREQ(4), .W(8), .TIMEOUT(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.req   = {pending[3] != 0, pending[2] != 0, pending[1] != 0, pending[0] != 0};
  assign bus.req_a = {opa[3], opa[2], opa[1], opa[0]};
  assign bus.req_b = {opb[3], opb[2], opb[1], opb[0]};
  assign bus.g_q   = sq;
  assign bus.g_rdy = stub_rdy | force_rdy;

  function automatic logic [7:0] gcd_f(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x, y, t;
    x = a;
    y = b;
    while (y != 8'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // gcd stub: result valid 4 edges after the edge that sees g_ld.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      cd       <= 0;
      stub_rdy <= 1'b0;
      sq       <= 8'd0;
    end else begin
      stub_rdy <= 1'b0;
      if (bus.g_ld) begin
        cd <= 3;
        sq <= gcd_f(bus.g_a, bus.g_b);
      end else if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) stub_rdy <= stub_en;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.ack != 4'd0) begin
      gr_ack.push_back(bus.ack);
      gr_a.push_back(bus.g_a);
      gr_b.push_back(bus.g_b);
      gr_ld.push_back(bus.g_ld);
      gr_cyc.push_back(cyc);
    end
    if (bus.rsp_done != 4'd0) begin
      dn_v.push_back(bus.rsp_done);
      dn_q.push_back(bus.rsp_q);
      dn_cyc.push_back(cyc);
    end
    if (bus.rsp_err != 4'd0) begin
      er_v.push_back(bus.rsp_err);
      er_cyc.push_back(cyc);
    end
    for (int i = 0; i < 4; i++) begin
      if (bus.ack[i] && pending[i] > 0) pending[i]--;
    end
  endtask

  task automatic clear_logs();
    gr_ack.delete(); gr_a.delete(); gr_b.delete(); gr_ld.delete(); gr_cyc.delete();
    dn_v.delete(); dn_q.delete(); dn_cyc.delete(); er_v.delete(); er_cyc.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) pending[i] = 0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      pending[i] = 0;
      opa[i] = 8'd0;
      opb[i] = 8'd0;
    end
    reset = 1'b0;
    repeat (3) tick();
    n_tests++;
    if ({bus.ack, bus.rsp_q, bus.rsp_done, bus.rsp_err, bus.g_a, bus.g_b, bus.g_ld} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: ack=%b q=%0d done=%b err=%b ga=%0d gb=%0d ld=%b required all 0",
               bus.ack, bus.rsp_q, bus.rsp_done, bus.rsp_err, bus.g_a, bus.g_b, bus.g_ld);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int c0;
    clear_logs();
    opa[0] = 8'd12;
    opb[0] = 8'd18;
    pending[0] = 1;
    c0 = cyc;
    for (int n = 0; n < 20 && dn_v.size() == 0; n++) tick();
    n_tests++;
    if (gr_ack.size() != 1 || dn_v.size() != 1) begin
      n_fail++;
      $display("FAIL single_counts: grants=%0d dones=%0d required 1 and 1", gr_ack.size(), dn_v.size());
    end else begin
      n_tests++;
      if (gr_ack[0] !== 4'b0001 || gr_ld[0] !== 1'b1 || gr_a[0] !== 8'd12 || gr_b[0] !== 8'd18) begin
        n_fail++;
        $display("FAIL single_grant: ack=%b ld=%b ga=%0d gb=%0d required 0001 1 12 18",
                 gr_ack[0], gr_ld[0], gr_a[0], gr_b[0]);
      end
      n_tests++;
      if (gr_cyc[0] != c0 + 1) begin
        n_fail++;
        $display("FAIL single_grant_latency: grant cycle %0d required %0d", gr_cyc[0], c0 + 1);
      end
      n_tests++;
      if (dn_v[0] !== 4'b0001 || dn_q[0] !== 8'd6) begin
        n_fail++;
        $display("FAIL single_result: done=%b q=%0d required 0001 6", dn_v[0], dn_q[0]);
      end
      n_tests++;
      if (dn_cyc[0] - gr_cyc[0] != 5) begin
        n_fail++;
        $display("FAIL single_done_latency: got %0d cycles required 5", dn_cyc[0] - gr_cyc[0]);
      end
    end
  endtask

  task automatic test_all_four();
    logic [3:0] eack [4];
    logic [7:0] eq [4];
    eack[0] = 4'b0001; eack[1] = 4'b0010; eack[2] = 4'b0100; eack[3] = 4'b1000;
    eq[0] = 8'd12; eq[1] = 8'd7; eq[2] = 8'd1; eq[3] = 8'd25;
    pulse_reset();
    clear_logs();
    opa[0] = 8'd48;  opb[0] = 8'd36;
    opa[1] = 8'd35;  opb[1] = 8'd14;
    opa[2] = 8'd17;  opb[2] = 8'd5;
    opa[3] = 8'd100; opb[3] = 8'd75;
    for (int i = 0; i < 4; i++) pending[i] = 1;
    for (int n = 0; n < 60 && dn_v.size() < 4; n++) tick();
    n_tests++;
    if (gr_ack.size() != 4 || dn_v.size() != 4) begin
      n_fail++;
      $display("FAIL all4_counts: grants=%0d dones=%0d required 4 and 4", gr_ack.size(), dn_v.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_tests++;
        if (gr_ack[i] !== eack[i] || dn_v[i] !== eack[i] || dn_q[i] !== eq[i]) begin
          n_fail++;
          $display("FAIL all4_op%0d: ack=%b done=%b q=%0d required %b %b %0d",
                   i, gr_ack[i], dn_v[i], dn_q[i], eack[i], eack[i], eq[i]);
        end
      end
      for (int i = 0; i < 3; i++) begin
        n_tests++;
        if (gr_cyc[i+1] - dn_cyc[i] != 1) begin
          n_fail++;
          $display("FAIL all4_back_to_back%0d: gap %0d required 1", i, gr_cyc[i+1] - dn_cyc[i]);
        end
      end
    end
  endtask

  task automatic test_fairness();
    logic [3:0] e;
    clear_logs();
    opa[1] = 8'd40; opb[1] = 8'd24;
    opa[3] = 8'd40; opb[3] = 8'd24;
    pending[1] = 4;
    pending[3] = 4;
    for (int n = 0; n < 120 && dn_v.size() < 8; n++) tick();
    n_tests++;
    if (gr_ack.size() != 8 || dn_v.size() != 8) begin
      n_fail++;
      $display("FAIL fair_counts: grants=%0d dones=%0d required 8 and 8", gr_ack.size(), dn_v.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        e = (i % 2 == 0) ? 4'b0010 : 4'b1000;
        n_tests++;
        if (gr_ack[i] !== e || dn_v[i] !== e || dn_q[i] !== 8'd8) begin
          n_fail++;
          $display("FAIL fair_op%0d: ack=%b done=%b q=%0d required %b %b 8",
                   i, gr_ack[i], dn_v[i], dn_q[i], e, e);
        end
      end
    end
  endtask

  task automatic test_spurious_rdy();
    clear_logs();
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    tick();
    n_tests++;
    if (dn_v.size() != 0 || gr_ack.size() != 0 || bus.rsp_q !== 8'd8) begin
      n_fail++;
      $display("FAIL spurious_idle: dones=%0d grants=%0d q=%0d required 0 0 8",
               dn_v.size(), gr_ack.size(), bus.rsp_q);
    end
    opa[0] = 8'd21;
    opb[0] = 8'd14;
    pending[0] = 1;
    tick();
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    for (int n = 0; n < 20 && dn_v.size() == 0; n++) tick();
    n_tests++;
    if (gr_ack.size() != 1 || dn_v.size() != 1) begin
      n_fail++;
      $display("FAIL spurious_ld_counts: grants=%0d dones=%0d required 1 and 1", gr_ack.size(), dn_v.size());
    end else begin
      n_tests++;
      if (gr_ack[0] !== 4'b0001 || dn_v[0] !== 4'b0001 || dn_q[0] !== 8'd7 || dn_cyc[0] - gr_cyc[0] != 5) begin
        n_fail++;
        $display("FAIL spurious_ld_result: ack=%b done=%b q=%0d lat=%0d required 0001 0001 7 5",
                 gr_ack[0], dn_v[0], dn_q[0], dn_cyc[0] - gr_cyc[0]);
      end
    end
  endtask

  task automatic test_reset_mid();
    clear_logs();
    opa[0] = 8'd12;
    opb[0] = 8'd18;
    pending[0] = 1;
    for (int n = 0; n < 10 && gr_ack.size() == 0; n++) tick();
    tick();
    tick();
    reset = 1'b0;
    #1;
    n_tests++;
    if ({bus.ack, bus.rsp_q, bus.rsp_done, bus.rsp_err, bus.g_a, bus.g_b, bus.g_ld} !== 37'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs: ack=%b q=%0d done=%b err=%b ga=%0d gb=%0d ld=%b required all 0",
               bus.ack, bus.rsp_q, bus.rsp_done, bus.rsp_err, bus.g_a, bus.g_b, bus.g_ld);
    end
    for (int i = 0; i < 4; i++) pending[i] = 0;
    repeat (8) tick();
    n_tests++;
    if (dn_v.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_no_done: dones=%0d required 0", dn_v.size());
    end
    reset = 1'b1;
    clear_logs();
    opa[2] = 8'd9;   opb[2] = 8'd6;
    opa[3] = 8'd100; opb[3] = 8'd75;
    pending[2] = 1;
    pending[3] = 1;
    for (int n = 0; n < 40 && dn_v.size() < 2; n++) tick();
    n_tests++;
    if (dn_v.size() != 2) begin
      n_fail++;
      $display("FAIL midreset_counts: dones=%0d required 2", dn_v.size());
    end else begin
      n_tests++;
      if (gr_ack[0] !== 4'b0100 || dn_v[0] !== 4'b0100 || dn_q[0] !== 8'd3) begin
        n_fail++;
        $display("FAIL midreset_first: ack=%b done=%b q=%0d required 0100 0100 3", gr_ack[0], dn_v[0], dn_q[0]);
      end
      n_tests++;
      if (gr_ack[1] !== 4'b1000 || dn_v[1] !== 4'b1000 || dn_q[1] !== 8'd25) begin
        n_fail++;
        $display("FAIL midreset_second: ack=%b done=%b q=%0d required 1000 1000 25", gr_ack[1], dn_v[1], dn_q[1]);
      end
    end
  endtask

`ifdef GCD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    clear_logs();
    stub_en = 1'b0;
    opa[0] = 8'd12;
    opb[0] = 8'd18;
    pending[0] = 1;
    for (int n = 0; n < 40 && er_v.size() == 0; n++) tick();
    n_tests++;
    if (er_v.size() != 1 || gr_ack.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_counts: errs=%0d grants=%0d required 1 and 1", er_v.size(), gr_ack.size());
    end else begin
      n_tests++;
      if (er_v[0] !== 4'b0001 || er_cyc[0] - gr_cyc[0] != 20 || dn_v.size() != 0 || bus.rsp_q !== 8'd25) begin
        n_fail++;
        $display("FAIL timeout_err: err=%b after=%0d dones=%0d q=%0d required 0001 20 0 25",
                 er_v[0], er_cyc[0] - gr_cyc[0], dn_v.size(), bus.rsp_q);
      end
    end
    stub_en = 1'b1;
    opa[1] = 8'd40;
    opb[1] = 8'd24;
    pending[1] = 1;
    for (int n = 0; n < 20 && dn_v.size() == 0; n++) tick();
    n_tests++;
    if (gr_ack.size() != 2 || dn_v.size() != 1) begin
      n_fail++;
      $display("FAIL timeout_next_counts: grants=%0d dones=%0d required 2 and 1", gr_ack.size(), dn_v.size());
    end else begin
      n_tests++;
      if (gr_ack[1] !== 4'b0010 || dn_v[0] !== 4'b0010 || dn_q[0] !== 8'd8) begin
        n_fail++;
        $display("FAIL timeout_next: ack=%b done=%b q=%0d required 0010 0010 8", gr_ack[1], dn_v[0], dn_q[0]);
      end
    end
  endtask
`else
  task automatic test_hang();
    clear_logs();
    stub_en = 1'b0;
    opa[0] = 8'd12;
    opb[0] = 8'd18;
    pending[0] = 1;
    for (int n = 0; n < 10 && gr_ack.size() == 0; n++) tick();
    opa[1] = 8'd40;
    opb[1] = 8'd24;
    pending[1] = 1;
    repeat (40) tick();
    n_tests++;
    if (dn_v.size() != 0 || er_v.size() != 0 || gr_ack.size() != 1) begin
      n_fail++;
      $display("FAIL hang_wait: dones=%0d errs=%0d grants=%0d required 0 0 1", dn_v.size(), er_v.size(), gr_ack.size());
    end
    force_rdy = 1'b1;
    tick();
    force_rdy = 1'b0;
    stub_en = 1'b1;
    for (int n = 0; n < 30 && dn_v.size() < 2; n++) tick();
    n_tests++;
    if (dn_v.size() != 2 || gr_ack.size() != 2) begin
      n_fail++;
      $display("FAIL hang_release_counts: dones=%0d grants=%0d required 2 and 2", dn_v.size(), gr_ack.size());
    end else begin
      n_tests++;
      if (dn_v[0] !== 4'b0001 || dn_q[0] !== 8'd6 || gr_ack[1] !== 4'b0010 || dn_q[1] !== 8'd8) begin
        n_fail++;
        $display("FAIL hang_release: done0=%b q0=%0d ack1=%b q1=%0d required 0001 6 0010 8",
                 dn_v[0], dn_q[0], gr_ack[1], dn_q[1]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_spurious_rdy();
    test_reset_mid();
`ifdef GCD_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_hang();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end
endmodule
